// File: rtl/agu_commit_arbiter.sv
// ============================================================================
// Module      : agu_commit_arbiter
// Description : Merges lookup/load/store results (up to two per cycle, fixed
//               priority) into a circular commit queue drained by one port.
//               Optional macro AGU_COMMIT_BYPASS_EN adds an empty-queue bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package agu_commit_pkg;
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  tag;
    } execute_to_commit_bus_t;
endpackage

module agu_commit_arbiter
    import agu_commit_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         lookup_valid,
    input  logic                         load_valid,
    input  logic                         store_valid,
    input  execute_to_commit_bus_t       lookup_bus,
    input  execute_to_commit_bus_t       load_bus,
    input  execute_to_commit_bus_t       store_bus,
    output logic                         lookup_allowin,
    output logic                         load_allowin,
    output logic                         store_allowin,
    output logic                         commit_valid,
    output execute_to_commit_bus_t       commit_bus,
    input  logic                         commit_ready,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_two   = c_cnt_w'(2);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    execute_to_commit_bus_t r_mem [DEPTH];
    logic [c_ptr_w-1:0]     r_head;
    logic [c_ptr_w-1:0]     r_tail;
    logic [c_cnt_w-1:0]     r_count;

    logic [c_cnt_w-1:0]     w_free;
    logic                   w_lk_acc, w_ld_acc, w_st_acc;
    logic                   w_first_v, w_second_v;
    execute_to_commit_bus_t w_first_bus, w_second_bus;
    logic                   w_q_valid;
    logic                   w_byp_vis, w_byp_take;
    logic                   w_deq;
    logic                   w_wr0_v, w_wr1_v;
    execute_to_commit_bus_t w_wr0_bus, w_wr1_bus;
    logic [1:0]             w_nwr;
    logic [c_ptr_w-1:0]     w_tail_p1;

    // Free space comes from the registered count only, so a dequeue in the
    // same cycle never opens room for a new request.
    assign w_free = c_depth - r_count;

    assign lookup_allowin = !flush && (w_free >= c_one);
    assign load_allowin   = !flush && ((w_free >= c_two) || ((w_free >= c_one) && !lookup_valid));
    assign store_allowin  = !flush && !(lookup_valid && load_valid) &&
                            ((lookup_valid || load_valid) ? (w_free >= c_two) : (w_free >= c_one));

    assign w_lk_acc = lookup_valid && lookup_allowin;
    assign w_ld_acc = load_valid   && load_allowin;
    assign w_st_acc = store_valid  && store_allowin;

    always_comb begin
        w_first_v    = 1'b0;
        w_first_bus  = '0;
        w_second_v   = 1'b0;
        w_second_bus = '0;
        if (w_lk_acc) begin
            w_first_v   = 1'b1;
            w_first_bus = lookup_bus;
            if (w_ld_acc) begin
                w_second_v   = 1'b1;
                w_second_bus = load_bus;
            end else if (w_st_acc) begin
                w_second_v   = 1'b1;
                w_second_bus = store_bus;
            end
        end else if (w_ld_acc) begin
            w_first_v   = 1'b1;
            w_first_bus = load_bus;
            if (w_st_acc) begin
                w_second_v   = 1'b1;
                w_second_bus = store_bus;
            end
        end else if (w_st_acc) begin
            w_first_v   = 1'b1;
            w_first_bus = store_bus;
        end
    end

    assign w_q_valid = (r_count != '0);

`ifdef AGU_COMMIT_BYPASS_EN
    assign w_byp_vis  = !w_q_valid && !flush && w_first_v;
    assign w_byp_take = w_byp_vis && commit_ready;
`else
    assign w_byp_vis  = 1'b0;
    assign w_byp_take = 1'b0;
`endif

    assign commit_valid = w_q_valid || w_byp_vis;
    assign commit_bus   = w_q_valid ? r_mem[r_head] :
                          (w_byp_vis ? w_first_bus : '0);

    assign w_deq = w_q_valid && commit_ready && !flush;

    // A consumed bypass request skips the queue; the second request, if any,
    // takes the tail slot alone.
    assign w_wr0_v   = w_byp_take ? w_second_v   : w_first_v;
    assign w_wr0_bus = w_byp_take ? w_second_bus : w_first_bus;
    assign w_wr1_v   = w_byp_take ? 1'b0         : w_second_v;
    assign w_wr1_bus = w_second_bus;

    assign w_nwr     = {1'b0, w_wr0_v} + {1'b0, w_wr1_v};
    assign w_tail_p1 = r_tail + c_ptr_w'(1);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_deq) begin
                r_head <= r_head + c_ptr_w'(1);
            end
            r_tail  <= r_tail + c_ptr_w'(w_nwr);
            r_count <= r_count + c_cnt_w'(w_nwr) - c_cnt_w'(w_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            if (w_wr0_v) begin
                r_mem[r_tail] <= w_wr0_bus;
            end
            if (w_wr1_v) begin
                r_mem[w_tail_p1] <= w_wr1_bus;
            end
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_agu_commit_arbiter.sv
// ============================================================================
// Module      : tb_agu_commit_arbiter
// Description : Scoreboard bench for agu_commit_arbiter (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_agu_commit_arbiter;
    import agu_commit_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset, flush;
    logic lookup_valid, load_valid, store_valid, commit_ready;
    execute_to_commit_bus_t lookup_bus, load_bus, store_bus, commit_bus;
    logic lookup_allowin, load_allowin, store_allowin, commit_valid;
    logic [$clog2(DEPTH):0] count;

    always #5 clk = ~clk;

    agu_commit_arbiter #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .lookup_valid   (lookup_valid),
        .load_valid     (load_valid),
        .store_valid    (store_valid),
        .lookup_bus     (lookup_bus),
        .load_bus       (load_bus),
        .store_bus      (store_bus),
        .lookup_allowin (lookup_allowin),
        .load_allowin   (load_allowin),
        .store_allowin  (store_allowin),
        .commit_valid   (commit_valid),
        .commit_bus     (commit_bus),
        .commit_ready   (commit_ready),
        .count          (count)
    );

    execute_to_commit_bus_t sb[$];
    int n_pass  = 0;
    int n_total = 0;
    int n_pop   = 0;
    int tag_q   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic execute_to_commit_bus_t mk(input int t);
        execute_to_commit_bus_t b;
        b.data = 32'hD000_0000 + t;
        b.tag  = t[7:0];
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit lv, input bit ldv, input bit sv, input bit rdy);
        tag_q++; lookup_bus = mk(tag_q);
        tag_q++; load_bus   = mk(tag_q);
        tag_q++; store_bus  = mk(tag_q);
        lookup_valid = lv;
        load_valid   = ldv;
        store_valid  = sv;
        commit_ready = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40 && count != '0; i++) tick();
        idle();
        chk("drain_empty", 64'(count), 64'd0);
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every accepted commit handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && flush === 1'b0 && commit_valid === 1'b1 && commit_ready === 1'b1) begin
            n_pop++;
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_commit: got %0h expected no commit", commit_bus);
            end else begin
                execute_to_commit_bus_t e;
                e = sb.pop_front();
                chk("commit_bus", 64'(commit_bus), 64'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        reset = 1'b1;
        flush = 1'b0;
        idle();
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_cvalid", 64'(commit_valid), 64'd0);
        chk("rst_cbus", 64'(commit_bus), 64'd0);
        chk("rst_allow", 64'({lookup_allowin, load_allowin, store_allowin}), 64'b111);
        tick();

        // Priority: three requesters, only lookup and load accepted
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        sb.push_back(lookup_bus);
        sb.push_back(load_bus);
        @(negedge clk);
        chk("prio_allow", 64'({lookup_allowin, load_allowin, store_allowin}), 64'b110);
        tick();
        idle();
        chk("prio_count", 64'(count), 64'd2);
        drain();

        // Full
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            sb.push_back(lookup_bus);
            sb.push_back(load_bus);
            tick();
        end
        idle();
        chk("full_count", 64'(count), 64'd8);
        @(negedge clk);
        chk("full_allow", 64'({lookup_allowin, load_allowin, store_allowin}), 64'b000);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("full_deq_count", 64'(count), 64'd7);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        sb.push_back(lookup_bus);
        @(negedge clk);
        chk("full_one_free_allow", 64'({lookup_allowin, load_allowin}), 64'b10);
        tick();
        idle();
        chk("full_refill_count", 64'(count), 64'd8);
        drain();

        // Wrap-around: 20 single pushes, ready every other cycle
        p0 = n_pop;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            sb.push_back(lookup_bus);
            tick();
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        idle();
        chk("wrap_pops", 64'(n_pop - p0), 64'd20);
        chk("wrap_count", 64'(count), 64'd0);

        // Simultaneous push and pop
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        sb.push_back(lookup_bus);
        sb.push_back(load_bus);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        sb.push_back(lookup_bus);
        tick();
        chk("simul_pre_count", 64'(count), 64'd3);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        sb.push_back(lookup_bus);
        sb.push_back(load_bus);
        tick();
        idle();
        chk("simul_count", 64'(count), 64'd4);
        drain();

        // Flush mid-operation
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            sb.push_back(lookup_bus);
            sb.push_back(load_bus);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        sb.push_back(store_bus);
        tick();
        chk("flush_pre_count", 64'(count), 64'd5);
        flush = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("flush_load_allow", 64'(load_allowin), 64'd0);
        tick();
        flush = 1'b0;
        idle();
        sb.delete();
        chk("flush_count", 64'(count), 64'd0);
        @(negedge clk);
        chk("flush_cvalid", 64'(commit_valid), 64'd0);
        chk("flush_cbus", 64'(commit_bus), 64'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        sb.push_back(lookup_bus);
        tick();
        idle();
        chk("flush_after_count", 64'(count), 64'd1);
        drain();

        // Bypass / latency
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        sb.push_back(lookup_bus);
        @(negedge clk);
`ifdef AGU_COMMIT_BYPASS_EN
        chk("byp_cvalid", 64'(commit_valid), 64'd1);
        chk("byp_cbus", 64'(commit_bus), 64'(lookup_bus));
        tick();
        idle();
        chk("byp_count", 64'(count), 64'd0);
`else
        chk("byp_cvalid", 64'(commit_valid), 64'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("byp_count", 64'(count), 64'd1);
        @(negedge clk);
        chk("byp_cvalid_late", 64'(commit_valid), 64'd1);
        tick();
        idle();
        chk("byp_count_after", 64'(count), 64'd0);
`endif
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        sb.push_back(lookup_bus);
        sb.push_back(load_bus);
        tick();
        idle();
`ifdef AGU_COMMIT_BYPASS_EN
        chk("byp2_count", 64'(count), 64'd1);
`else
        chk("byp2_count", 64'(count), 64'd2);
`endif
        drain();

        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/agu_commit_arbiter.md
AGU_COMMIT_ARBITER -- requirements
Module: agu_commit_arbiter

Interface
REQ-001 SHALL take parameter DEPTH, default 8, queue entry count; power of two, DEPTH >= 4.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port flush, input, 1, pipeline flush; acts like reset on queue state.
REQ-005 SHALL have ports lookup_valid / load_valid / store_valid, input, 1 each, requester result valid.
REQ-006 SHALL have ports lookup_bus / load_bus / store_bus, input, execute_to_commit_bus_t each, requester payload.
REQ-007 SHALL have ports lookup_allowin / load_allowin / store_allowin, output, 1 each; a requester is accepted when its valid && allowin.
REQ-008 SHALL have port commit_valid, output, 1, head entry present.
REQ-009 SHALL have port commit_bus, output, execute_to_commit_bus_t, head payload; all-zero when commit_valid=0.
REQ-010 SHALL have port commit_ready, input, 1, commit port consumes the entry this cycle.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1, registered occupancy.

Function
REQ-012 SHALL hold a circular FIFO: head and tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, plus count.
REQ-013 SHALL accept at most 2 requests per cycle; fixed priority lookup > load > store.
REQ-014 SHALL compute free = DEPTH - count from the registered count; same-cycle dequeue SHALL NOT add free space.
REQ-015 SHALL drive lookup_allowin = !flush && free>=1.
REQ-016 SHALL drive load_allowin = !flush && (free>=2 || (free>=1 && !lookup_valid)).
REQ-017 SHALL drive store_allowin = !flush && !(lookup_valid && load_valid) && free >= 1 + (lookup_valid || load_valid).
REQ-018 SHALL write accepted requests in priority order: first to tail, second to tail+1 (wrapped); tail advances by the accepted count.
REQ-019 SHALL drive commit_valid = (count != 0); commit_bus = entry[head].
REQ-020 SHALL dequeue when commit_valid && commit_ready; head += 1.
REQ-021 SHALL update count_next = count + accepted - dequeued, with simultaneous enqueue and dequeue in one cycle.
REQ-022 SHALL have minimum latency 1 cycle from acceptance to commit_valid (without REQ-029).
REQ-023 SHALL never overflow or underflow by construction.

Reset
REQ-024 SHALL, on reset, clear head, tail and count to 0 on the next edge.
REQ-025 SHALL, after reset, hold commit_valid=0 and commit_bus=0; allowins reflect free=DEPTH.
REQ-026 SHALL, on flush, clear head, tail and count to 0 on the next edge; same-cycle requests and dequeue are discarded.
REQ-027 SHALL force all allowins to 0 during flush.
REQ-028 SHALL NOT reset entry storage; it is unobservable while count=0.

Configuration
REQ-029 SHALL, when AGU_COMMIT_BYPASS_EN is defined and count==0 && !flush, drive the highest-priority accepted request combinationally on commit_bus with commit_valid=1.
  - If commit_ready, that request SHALL NOT be enqueued; any second accepted request SHALL be enqueued alone.
  - If !commit_ready, both requests SHALL be enqueued normally.
REQ-030 SHALL, when AGU_COMMIT_BYPASS_EN is undefined, never use a bypass path; latency is exactly as in REQ-022.

Verification
REQ-031 SHALL test priority: count=0, lookup+load+store valid, ready=0 -> store_allowin=0; entries lookup then load; count=2 next cycle.
REQ-032 SHALL test full: fill to count=8, ready=0 -> all allowins=0; one dequeue -> next cycle count=7 and lookup_allowin=1, load_allowin=0 when lookup_valid=1.
REQ-033 SHALL test wrap-around: 20 single pushes with ready=1 every other cycle -> commit order equals push order; pointers wrap with no loss.
REQ-034 SHALL test simultaneous push and pop: count=3, two pushes plus one dequeue -> count=4.
REQ-035 SHALL test flush mid-operation: count=5, flush with load_valid=1 -> count=0 next cycle, commit_valid=0, load not stored.
REQ-036 SHALL test bypass: with AGU_COMMIT_BYPASS_EN, count=0, lookup_valid=1, ready=1 -> commit_bus=lookup_bus same cycle and count stays 0; without the macro -> commit_valid=1 one cycle later.
